// File: rtl/pn_seq_engine.sv
// Run-time configurable Fibonacci LFSR sequence engine with step or prescaled free-run advance.
// Optional period measurement is compiled in when PN_PERIOD_EN is defined.
module pn_seq_engine #(
  parameter int              WIDTH    = 13,
  parameter int              SEED     = 2,
  parameter logic [WIDTH-1:0] POLY_RST = 13'h1C80,
  parameter int              PSC_W    = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         step,
  input  logic                         mode,
  input  logic [PSC_W-1:0]             rate,
  input  logic [$clog2(WIDTH+1)-1:0]   ord,
  input  logic [WIDTH-1:0]             poly,
  input  logic                         poly_vld,
  output logic [WIDTH-1:0]             seq_out,
  output logic                         seq_vld,
  output logic                         lockup,
  output logic [WIDTH-1:0]             period,
  output logic                         period_vld
);
  localparam int OW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {LOAD, RUN, LOCK} st_t;

  st_t              st;
  logic [OW-1:0]    ord_r;
  logic [WIDTH-1:0] poly_r;
  logic [PSC_W-1:0] psc;
  logic             mode_q;
  logic             adv;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] seed;

  function automatic logic [OW-1:0] clamp_ord(input logic [OW-1:0] o);
    if (o < OW'(2))     return OW'(2);
    if (o > OW'(WIDTH)) return OW'(WIDTH);
    return o;
  endfunction

  function automatic logic [WIDTH-1:0] mask_of(input logic [OW-1:0] o);
    logic [WIDTH-1:0] m;
    for (int i = 0; i < WIDTH; i++) m[i] = (i < int'(o));
    return m;
  endfunction

  // A seed that masks to zero would park the register in lock-up, so fall back to 1.
  function automatic logic [WIDTH-1:0] seed_of(input logic [OW-1:0] o);
    logic [WIDTH-1:0] s;
    s = WIDTH'(SEED) & mask_of(o);
    if (s == '0) s = WIDTH'(1);
    return s;
  endfunction

  assign nxt  = {seq_out[WIDTH-2:0], ^(seq_out & poly_r & mask_of(ord_r))} & mask_of(ord_r);
  assign seed = seed_of(ord_r);
  assign adv  = (st == RUN) && !poly_vld && (mode ? (mode_q && psc == '0) : step);

  // Entering lock-up is signalled by lockup alone; seq_vld stays low for that transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= LOAD;
      ord_r   <= OW'(WIDTH);
      poly_r  <= POLY_RST;
      seq_out <= seed_of(OW'(WIDTH));
      mode_q  <= 1'b0;
      seq_vld <= 1'b0;
      lockup  <= 1'b0;
    end else begin
      seq_vld <= 1'b0;
      mode_q  <= mode;
      if (poly_vld) begin
        ord_r   <= clamp_ord(ord);
        poly_r  <= poly;
        seq_out <= seed_of(clamp_ord(ord));
        lockup  <= 1'b0;
        st      <= LOAD;
      end else begin
        case (st)
          LOAD: begin
            seq_out <= seed;
            lockup  <= 1'b0;
            st      <= RUN;
          end
          RUN: begin
            if (adv) begin
              seq_out <= nxt;
              if (nxt == '0) begin
                lockup <= 1'b1;
                st     <= LOCK;
              end else begin
                seq_vld <= 1'b1;
              end
            end
          end
          LOCK:    lockup <= 1'b1;
          default: st <= LOAD;
        endcase
      end
    end
  end

  // Free-run down-counter; a 0->1 mode edge restarts the interval from the current rate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc <= '0;
    end else if (st == LOAD || (mode && (!mode_q || psc == '0))) begin
      psc <= rate;
    end else if (mode) begin
      psc <= psc - PSC_W'(1);
    end
  end

`ifdef PN_PERIOD_EN
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      period     <= '0;
      period_vld <= 1'b0;
    end else begin
      period_vld <= 1'b0;
      if (poly_vld || st == LOAD) begin
        cnt <= '0;
      end else if (adv) begin
        if (nxt == seed) begin
          if (cnt != '1) begin
            period     <= cnt + WIDTH'(1);
            period_vld <= 1'b1;
          end
          cnt <= '0;
        end else if (cnt != '1) begin
          cnt <= cnt + WIDTH'(1);
        end
      end
    end
  end
`else
  assign period     = '0;
  assign period_vld = 1'b0;
`endif

endmodule

// File: tb/tb_pn_seq_engine.sv
// Bench for pn_seq_engine: directed scenarios plus randomized traffic against a behavioural model.
module tb_pn_seq_engine;
  localparam int W = 13;

  logic        clk = 1'b0;
  logic        rst, step, mode, poly_vld;
  logic [19:0] rate;
  logic [3:0]  ord;
  logic [12:0] poly;
  logic [12:0] seq_out, period;
  logic        seq_vld, lockup, period_vld;

  int npass = 0;
  int ntot  = 0;

  int m_ord, m_poly, m_state, m_cnt, m_acnt, m_period;
  bit m_loading, m_locked, m_prevmode, m_vld, m_pvld;

  always #5 clk = ~clk;

  pn_seq_engine dut (
    .clk(clk), .rst(rst), .step(step), .mode(mode), .rate(rate), .ord(ord),
    .poly(poly), .poly_vld(poly_vld), .seq_out(seq_out), .seq_vld(seq_vld),
    .lockup(lockup), .period(period), .period_vld(period_vld)
  );

  task automatic chk(input string name, input int act, input int exp);
    ntot++;
    if (act != exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else npass++;
  endtask

  function automatic int f_mask(input int o);
    return (1 << o) - 1;
  endfunction

  function automatic int f_seed(input int o);
    int s;
    s = 2 & f_mask(o);
    return (s == 0) ? 1 : s;
  endfunction

  function automatic int f_next(input int s, input int p, input int o);
    int par;
    par = 0;
    for (int i = 0; i < o; i++)
      if (((s >> i) & 1) == 1 && ((p >> i) & 1) == 1) par ^= 1;
    return ((s << 1) | par) & f_mask(o);
  endfunction

  function automatic int f_clamp(input int o);
    return (o < 2) ? 2 : ((o > W) ? W : o);
  endfunction

  // Predict the outputs that the coming clock edge must produce from the current inputs.
  task automatic model_step();
    bit a;
    int n;
    a = !m_loading && !m_locked && !poly_vld &&
        (mode ? (m_prevmode && m_cnt == 0) : step);
    if (m_loading || (mode && (!m_prevmode || m_cnt == 0))) m_cnt = int'(rate);
    else if (mode) m_cnt--;
    m_vld  = 0;
    m_pvld = 0;
    if (poly_vld) begin
      m_ord     = f_clamp(int'(ord));
      m_poly    = int'(poly);
      m_state   = f_seed(m_ord);
      m_loading = 1;
      m_locked  = 0;
      m_acnt    = 0;
    end else if (m_loading) begin
      m_state   = f_seed(m_ord);
      m_loading = 0;
      m_acnt    = 0;
    end else if (a) begin
      n = f_next(m_state, m_poly, m_ord);
`ifdef PN_PERIOD_EN
      if (n == f_seed(m_ord)) begin
        if (m_acnt != (1 << W) - 1) begin
          m_period = m_acnt + 1;
          m_pvld   = 1;
        end
        m_acnt = 0;
      end else if (m_acnt != (1 << W) - 1) begin
        m_acnt++;
      end
`endif
      m_state = n;
      if (n == 0) m_locked = 1;
      else m_vld = 1;
    end
    m_prevmode = mode;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("seq_out", int'(seq_out), m_state);
    chk("seq_vld", int'(seq_vld), int'(m_vld));
    chk("lockup", int'(lockup), int'(m_locked));
    chk("period", int'(period), m_period);
    chk("period_vld", int'(period_vld), int'(m_pvld));
  endtask

  task automatic load_cfg(input int o, input int p);
    poly_vld = 1; ord = 4'(o); poly = 13'(p); step = 0;
    cyc();
    poly_vld = 0;
    cyc();
  endtask

  initial begin
    int lit2 [3] = '{4, 9, 3};
    int lit5 [3] = '{4, 8, 0};
    int vcount;

    rst = 0; step = 0; mode = 0; rate = '0; ord = '0; poly = '0; poly_vld = 0;
    m_ord = W; m_poly = 'h1C80; m_state = 2; m_cnt = 0; m_acnt = 0; m_period = 0;
    m_loading = 1; m_locked = 0; m_prevmode = 0; m_vld = 0; m_pvld = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seq_out", int'(seq_out), 2);
    chk("rst_seq_vld", int'(seq_vld), 0);
    chk("rst_lockup", int'(lockup), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_period_vld", int'(period_vld), 0);
    rst = 1;
    cyc();
    step = 1; cyc();
    chk("first_step", int'(seq_out), 4);
    step = 0; cyc();

    load_cfg(4, 'hC);
    for (int i = 0; i < 3; i++) begin
      step = 1; cyc();
      chk("t2_seq", int'(seq_out), lit2[i]);
      chk("t2_vld", int'(seq_vld), 1);
      step = 0; cyc();
    end

    load_cfg(4, 'hC);
    step = 1;
    repeat (15) cyc();
    chk("t3_wrap", int'(seq_out), 2);
`ifdef PN_PERIOD_EN
    chk("t3_period", int'(period), 15);
    chk("t3_pvld", int'(period_vld), 1);
`endif
    step = 0; cyc();

    mode = 1; rate = 20'd3; vcount = 0;
    for (int i = 0; i < 20; i++) begin
      step = 1'($urandom_range(0, 1));
      cyc();
      vcount += int'(seq_vld);
    end
    chk("t4_adv_count", vcount, 4);
    mode = 0; step = 0; cyc();

    load_cfg(4, 'h1);
    for (int i = 0; i < 3; i++) begin
      step = 1; cyc();
      chk("t5_seq", int'(seq_out), lit5[i]);
      step = 0; cyc();
    end
    chk("t5_lockup", int'(lockup), 1);
    step = 1; repeat (2) cyc();
    chk("t5_held", int'(seq_out), 0);
    load_cfg(4, 'hC);
    chk("t5_cleared", int'(lockup), 0);

    poly_vld = 1; step = 1; ord = 4'd0; poly = 13'h3;
    cyc();
    chk("t6_seq", int'(seq_out), 2);
    chk("t6_vld", int'(seq_vld), 0);
    poly_vld = 0; step = 0; cyc();

    for (int i = 0; i < 500; i++) begin
      poly_vld = ($urandom_range(0, 24) == 0);
      if (poly_vld) begin
        ord  = 4'($urandom_range(0, 15));
        poly = 13'($urandom);
      end
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) rate = 20'($urandom_range(0, 4));
      step = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
